forward_ctrl_unit: RTL and testbench

- Sequential forwarding/hazard controller for the 5-stage pipelined CPU.
- Drives the 2-bit select_i of the two EX-stage operand 3-to-1 muxes (ALU src A, src B).
- Tracks destination info of in-flight instructions in internal EX and MEM shadow records.
- Issues a one-cycle load-use stall and counts stalls for performance reporting.

---
 rtl/cpu_pkg.sv | 24 ++
 rtl/fwd_select.sv | 49 ++++
 rtl/forward_ctrl_unit.sv | 140 ++++++++++++++
 tb/tb_forward_ctrl_unit.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU pipeline definitions: forwarding select codes, register address
// width and the per-stage destination record used by the hazard logic.
package cpu_pkg;

  localparam int unsigned REG_AW = 5;
  localparam int unsigned FWD_W  = 2;

  // Operand mux select codes; 2'b11 is never produced.
  localparam logic [FWD_W-1:0] FWD_REGFILE = 2'b00;
  localparam logic [FWD_W-1:0] FWD_MEMWB   = 2'b01;
  localparam logic [FWD_W-1:0] FWD_EXMEM   = 2'b10;

  // Destination info carried alongside an in-flight instruction.
  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic              regwrite;
    logic              memread;
  } pipe_rec_t;

  // Empty pipeline slot.
  localparam pipe_rec_t PIPE_BUBBLE = '0;

endpackage

// File: rtl/fwd_select.sv
// Forwarding select for one EX operand.
// Ports:
//   use_src            - consumer actually reads this operand
//   src                - consumer source register
//   ex_valid/ex_regwrite/ex_rd    - producer record now in EX (youngest)
//   mem_valid/mem_regwrite/mem_rd - producer record now in MEM
//   sel_c              - mux select for the next cycle (combinational)
//   ex_rd_eq_c         - raw EX destination equality, reused by the load-use check
module fwd_select #(
  parameter int unsigned REG_AW = 5
) (
  input  logic              use_src,
  input  logic [REG_AW-1:0] src,
  input  logic              ex_valid,
  input  logic              ex_regwrite,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              mem_valid,
  input  logic              mem_regwrite,
  input  logic [REG_AW-1:0] mem_rd,
  output logic [1:0]        sel_c,
  output logic              ex_rd_eq_c
);
  import cpu_pkg::FWD_REGFILE;
  import cpu_pkg::FWD_MEMWB;
  import cpu_pkg::FWD_EXMEM;

  logic ex_hit_c;
  logic mem_hit_c;

  // Producer match; register 0 is hardwired and never forwards.
  always_comb begin
    ex_rd_eq_c = (ex_rd == src);
    ex_hit_c   = ex_valid && ex_regwrite && (ex_rd != '0) && ex_rd_eq_c;
    mem_hit_c  = mem_valid && mem_regwrite && (mem_rd != '0) && (mem_rd == src);
  end

  // Youngest producer (EX/MEM) takes priority over the older one (MEM/WB).
  always_comb begin
    sel_c = FWD_REGFILE;
    if (use_src) begin
      if (ex_hit_c) begin
        sel_c = FWD_EXMEM;
      end else if (mem_hit_c) begin
        sel_c = FWD_MEMWB;
      end
    end
  end

endmodule

// File: rtl/forward_ctrl_unit.sv
// Forwarding / load-use hazard controller for the 5-stage pipeline.
// Ports:
//   clk_i, rst_i        - clock (rising edge), synchronous active-low reset
//   id_*                - decoded fields of the instruction currently in ID
//   flush_i             - taken branch/jump kills the ID instruction
//   fwd_a_o / fwd_b_o   - registered ALU src A/B selects, valid while the
//                         consumer is in EX
//   stall_o             - combinational load-use stall (hold PC and IF/ID)
//   stall_cnt_o         - saturating count of stall cycles
module forward_ctrl_unit #(
  parameter int unsigned REG_AW = 5,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              id_valid_i,
  input  logic [REG_AW-1:0] id_rs_i,
  input  logic [REG_AW-1:0] id_rt_i,
  input  logic              id_use_rs_i,
  input  logic              id_use_rt_i,
  input  logic [REG_AW-1:0] id_rd_i,
  input  logic              id_regwrite_i,
  input  logic              id_memread_i,
  input  logic              flush_i,
  output logic [1:0]        fwd_a_o,
  output logic [1:0]        fwd_b_o,
  output logic              stall_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);
  import cpu_pkg::pipe_rec_t;
  import cpu_pkg::PIPE_BUBBLE;
  import cpu_pkg::FWD_REGFILE;

  localparam int unsigned      REC_AW  = cpu_pkg::REG_AW;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  pipe_rec_t        ex_q;
  pipe_rec_t        mem_q;
  pipe_rec_t        ex_d;
  pipe_rec_t        mem_d;
  pipe_rec_t        id_rec_c;
  logic [1:0]       sel_a_c;
  logic [1:0]       sel_b_c;
  logic [1:0]       fwd_a_d;
  logic [1:0]       fwd_b_d;
  logic [CNT_W-1:0] cnt_d;
  logic             a_ex_eq_c;
  logic             b_ex_eq_c;
  logic             ex_load_c;
  logic             load_use_c;
  logic             unused_mem_memread;

  // The MEM record keeps memread so it mirrors the EX record; nothing here reads it.
  assign unused_mem_memread = mem_q.memread;

  // Pack the ID instruction into the record it will occupy in EX.
  always_comb begin
    id_rec_c          = PIPE_BUBBLE;
    id_rec_c.valid    = id_valid_i;
    id_rec_c.rd       = REC_AW'(id_rd_i);
    id_rec_c.regwrite = id_regwrite_i;
    id_rec_c.memread  = id_memread_i;
  end

  fwd_select #(
    .REG_AW (REG_AW)
  ) u_sel_a (
    .use_src      (id_use_rs_i),
    .src          (id_rs_i),
    .ex_valid     (ex_q.valid),
    .ex_regwrite  (ex_q.regwrite),
    .ex_rd        (REG_AW'(ex_q.rd)),
    .mem_valid    (mem_q.valid),
    .mem_regwrite (mem_q.regwrite),
    .mem_rd       (REG_AW'(mem_q.rd)),
    .sel_c        (sel_a_c),
    .ex_rd_eq_c   (a_ex_eq_c)
  );

  fwd_select #(
    .REG_AW (REG_AW)
  ) u_sel_b (
    .use_src      (id_use_rt_i),
    .src          (id_rt_i),
    .ex_valid     (ex_q.valid),
    .ex_regwrite  (ex_q.regwrite),
    .ex_rd        (REG_AW'(ex_q.rd)),
    .mem_valid    (mem_q.valid),
    .mem_regwrite (mem_q.regwrite),
    .mem_rd       (REG_AW'(mem_q.rd)),
    .sel_c        (sel_b_c),
    .ex_rd_eq_c   (b_ex_eq_c)
  );

  // Load-use hazard: a load in EX whose result the ID instruction reads.
  // A flush kills the consumer, so it suppresses the stall.
  always_comb begin
    ex_load_c  = ex_q.valid && ex_q.memread && (ex_q.rd != '0);
    load_use_c = id_valid_i && !flush_i && ex_load_c &&
                 ((id_use_rs_i && a_ex_eq_c) || (id_use_rt_i && b_ex_eq_c));
  end

  assign stall_o = load_use_c;

  // Next state: records always advance; a stall or flush injects a bubble
  // into EX and zeroes the selects so the bubble reads the register file.
  always_comb begin
    mem_d   = ex_q;
    ex_d    = id_rec_c;
    fwd_a_d = sel_a_c;
    fwd_b_d = sel_b_c;
    cnt_d   = stall_cnt_o;
    if (flush_i || load_use_c) begin
      ex_d    = PIPE_BUBBLE;
      fwd_a_d = FWD_REGFILE;
      fwd_b_d = FWD_REGFILE;
    end
    if (load_use_c && (stall_cnt_o != CNT_MAX)) begin
      cnt_d = stall_cnt_o + CNT_W'(1);
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      ex_q        <= PIPE_BUBBLE;
      mem_q       <= PIPE_BUBBLE;
      fwd_a_o     <= FWD_REGFILE;
      fwd_b_o     <= FWD_REGFILE;
      stall_cnt_o <= '0;
    end else begin
      ex_q        <= ex_d;
      mem_q       <= mem_d;
      fwd_a_o     <= fwd_a_d;
      fwd_b_o     <= fwd_b_d;
      stall_cnt_o <= cnt_d;
    end
  end

endmodule

// File: tb/tb_forward_ctrl_unit.sv
// Self-checking bench for forward_ctrl_unit: directed vector table, random
// stimulus against a behavioural model, counter saturation and reset-in-stall.
module tb_forward_ctrl_unit;

  localparam int unsigned AW      = 5;
  localparam int unsigned CW      = 10;
  localparam int          CNT_MAX = (1 << CW) - 1;

  logic          clk;
  logic          rst_i;
  logic          id_valid_i;
  logic [AW-1:0] id_rs_i;
  logic [AW-1:0] id_rt_i;
  logic          id_use_rs_i;
  logic          id_use_rt_i;
  logic [AW-1:0] id_rd_i;
  logic          id_regwrite_i;
  logic          id_memread_i;
  logic          flush_i;
  logic [1:0]    fwd_a_o;
  logic [1:0]    fwd_b_o;
  logic          stall_o;
  logic [CW-1:0] stall_cnt_o;

  forward_ctrl_unit #(
    .REG_AW (AW),
    .CNT_W  (CW)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .id_valid_i    (id_valid_i),
    .id_rs_i       (id_rs_i),
    .id_rt_i       (id_rt_i),
    .id_use_rs_i   (id_use_rs_i),
    .id_use_rt_i   (id_use_rt_i),
    .id_rd_i       (id_rd_i),
    .id_regwrite_i (id_regwrite_i),
    .id_memread_i  (id_memread_i),
    .flush_i       (flush_i),
    .fwd_a_o       (fwd_a_o),
    .fwd_b_o       (fwd_b_o),
    .stall_o       (stall_o),
    .stall_cnt_o   (stall_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          rst_n;
    logic          valid;
    logic [AW-1:0] rs;
    logic [AW-1:0] rt;
    logic          urs;
    logic          urt;
    logic [AW-1:0] rd;
    logic          rw;
    logic          mr;
    logic          flush;
  } in_t;

  typedef struct {
    in_t        i;
    logic       stall;
    logic [1:0] fa;
    logic [1:0] fb;
    int         cnt;
  } vec_t;

  typedef struct {
    logic v;
    int   rd;
    logic rw;
    logic mr;
  } mrec_t;

  int checks = 0;
  int errors = 0;

  // Behavioural model: the two older instructions, youngest first.
  mrec_t      m_ex;
  mrec_t      m_mem;
  logic [1:0] m_fa;
  logic [1:0] m_fb;
  int         m_cnt;
  logic       m_stall;

  // Sampled DUT values from the last cycle.
  logic       s_stall;
  logic [1:0] s_fa;
  logic [1:0] s_fb;
  int         s_cnt;

  vec_t tbl[$];

  function automatic in_t mk(logic rst_n, logic valid, int rs, int rt, logic urs, logic urt,
                             int rd, logic rw, logic mr, logic flush);
    in_t x;
    x.rst_n = rst_n; x.valid = valid;
    x.rs = AW'(rs); x.rt = AW'(rt); x.urs = urs; x.urt = urt;
    x.rd = AW'(rd); x.rw = rw; x.mr = mr; x.flush = flush;
    return x;
  endfunction

  task automatic add_vec(input in_t x, input logic st, input logic [1:0] fa,
                         input logic [1:0] fb, input int cnt);
    vec_t v;
    v.i = x; v.stall = st; v.fa = fa; v.fb = fb; v.cnt = cnt;
    tbl.push_back(v);
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Nearest older producer of register r wins; r0 never forwards.
  function automatic logic [1:0] model_sel(logic use_r, logic [AW-1:0] r);
    mrec_t      prod [2];
    logic [1:0] code [2];
    prod[0] = m_ex;  code[0] = 2'b10;
    prod[1] = m_mem; code[1] = 2'b01;
    if (!use_r) return 2'b00;
    for (int k = 0; k < 2; k++) begin
      if (prod[k].v && prod[k].rw && prod[k].rd != 0 && prod[k].rd == int'(r)) return code[k];
    end
    return 2'b00;
  endfunction

  function automatic logic model_stall(in_t x);
    logic reads_load;
    reads_load = (x.urs && m_ex.rd == int'(x.rs)) || (x.urt && m_ex.rd == int'(x.rt));
    return x.valid && !x.flush && m_ex.v && m_ex.mr && m_ex.rd != 0 && reads_load;
  endfunction

  task automatic model_step(input in_t x, input logic st);
    mrec_t bubble;
    mrec_t nxt;
    bubble = '{v: 1'b0, rd: 0, rw: 1'b0, mr: 1'b0};
    if (!x.rst_n) begin
      m_ex = bubble; m_mem = bubble; m_fa = 2'b00; m_fb = 2'b00; m_cnt = 0;
    end else if (st || x.flush) begin
      m_mem = m_ex; m_ex = bubble; m_fa = 2'b00; m_fb = 2'b00;
      if (st && m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
    end else begin
      m_fa = model_sel(x.urs, x.rs);
      m_fb = model_sel(x.urt, x.rt);
      nxt = '{v: x.valid, rd: int'(x.rd), rw: x.rw, mr: x.mr};
      m_mem = m_ex; m_ex = nxt;
    end
  endtask

  // One clock: drive ID, sample stall before the edge, registered outputs after.
  task automatic run_cycle(input in_t x);
    rst_i = x.rst_n; id_valid_i = x.valid; id_rs_i = x.rs; id_rt_i = x.rt;
    id_use_rs_i = x.urs; id_use_rt_i = x.urt; id_rd_i = x.rd;
    id_regwrite_i = x.rw; id_memread_i = x.mr; flush_i = x.flush;
    #1;
    m_stall = model_stall(x);
    s_stall = stall_o;
    @(posedge clk);
    model_step(x, m_stall);
    #1;
    s_fa = fwd_a_o; s_fb = fwd_b_o; s_cnt = int'(stall_cnt_o);
  endtask

  task automatic check_model(input string tag);
    check({tag, ".stall"}, 32'(s_stall), 32'(m_stall));
    check({tag, ".fwd_a"}, 32'(s_fa), 32'(m_fa));
    check({tag, ".fwd_b"}, 32'(s_fb), 32'(m_fb));
    check({tag, ".cnt"},   32'(s_cnt), 32'(m_cnt));
  endtask

  initial begin
    in_t idle;
    in_t ld;
    int  guard;

    idle = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    m_ex = '{v: 1'b0, rd: 0, rw: 1'b0, mr: 1'b0};
    m_mem = m_ex; m_fa = 2'b00; m_fb = 2'b00; m_cnt = 0;

    // Bring state out of X before the directed table.
    run_cycle(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    //                rst v  rs rt urs urt rd rw mr fl     stall fa     fb     cnt
    add_vec(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 0, 2'b00, 2'b00, 0); // reset
    add_vec(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 0, 2'b00, 2'b00, 0); // reset
    add_vec(mk(1, 1, 1, 2, 1, 1, 3, 1, 0, 0), 0, 2'b00, 2'b00, 0); // add $3,$1,$2
    add_vec(mk(1, 1, 3, 5, 1, 1, 4, 1, 0, 0), 0, 2'b10, 2'b00, 0); // sub $4,$3,$5
    add_vec(mk(1, 1, 1, 2, 1, 1, 3, 1, 0, 0), 0, 2'b00, 2'b00, 0); // add $3
    add_vec(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0), 0, 2'b00, 2'b00, 0); // nop
    add_vec(mk(1, 1, 7, 3, 1, 1, 6, 1, 0, 0), 0, 2'b00, 2'b01, 0); // or $6,$7,$3
    add_vec(mk(1, 1, 1, 2, 1, 1, 3, 1, 0, 0), 0, 2'b00, 2'b00, 0); // add $3
    add_vec(mk(1, 1, 1, 2, 1, 1, 3, 1, 0, 0), 0, 2'b00, 2'b00, 0); // add $3
    add_vec(mk(1, 1, 3, 3, 1, 1, 8, 1, 0, 0), 0, 2'b10, 2'b10, 0); // and $8,$3,$3
    add_vec(mk(1, 1, 1, 2, 1, 1, 0, 1, 0, 0), 0, 2'b00, 2'b00, 0); // add $0,$1,$2
    add_vec(mk(1, 1, 0, 0, 1, 1, 9, 1, 0, 0), 0, 2'b00, 2'b00, 0); // sub $9,$0,$0
    add_vec(mk(1, 1, 1, 2, 1, 0, 2, 1, 1, 0), 0, 2'b00, 2'b00, 0); // lw $2,0($1)
    add_vec(mk(1, 1, 2, 2, 1, 1, 4, 1, 0, 0), 1, 2'b00, 2'b00, 1); // add $4,$2,$2 stall
    add_vec(mk(1, 1, 2, 2, 1, 1, 4, 1, 0, 0), 0, 2'b01, 2'b01, 1); // held, from MEM/WB
    add_vec(mk(1, 1, 1, 5, 1, 0, 5, 1, 1, 0), 0, 2'b00, 2'b00, 1); // lw $5,0($1)
    add_vec(mk(1, 1, 5, 0, 1, 1, 6, 1, 0, 1), 0, 2'b00, 2'b00, 1); // consumer flushed
    add_vec(mk(1, 1, 5, 5, 1, 1, 7, 1, 0, 0), 0, 2'b01, 2'b01, 1); // or $7,$5,$5
    add_vec(mk(1, 1, 1, 5, 1, 0, 5, 1, 1, 0), 0, 2'b00, 2'b00, 1); // lw $5
    add_vec(mk(1, 1, 5, 5, 1, 1, 6, 1, 0, 0), 1, 2'b00, 2'b00, 2); // stall
    add_vec(mk(1, 1, 5, 5, 1, 1, 6, 1, 0, 0), 0, 2'b01, 2'b01, 2); // held
    add_vec(mk(1, 1, 1, 5, 1, 0, 5, 1, 1, 0), 0, 2'b00, 2'b00, 2); // lw $5
    add_vec(mk(0, 1, 5, 5, 1, 1, 6, 1, 0, 0), 1, 2'b00, 2'b00, 0); // reset mid-stall
    add_vec(mk(1, 1, 5, 5, 1, 1, 6, 1, 0, 0), 0, 2'b00, 2'b00, 0); // nothing retained

    foreach (tbl[k]) begin
      run_cycle(tbl[k].i);
      check($sformatf("vec%0d.stall", k), 32'(s_stall), 32'(tbl[k].stall));
      check($sformatf("vec%0d.fwd_a", k), 32'(s_fa), 32'(tbl[k].fa));
      check($sformatf("vec%0d.fwd_b", k), 32'(s_fb), 32'(tbl[k].fb));
      check($sformatf("vec%0d.cnt", k),   32'(s_cnt), 32'(tbl[k].cnt));
    end

    // Random traffic on a small register window so hazards are frequent.
    for (int n = 0; n < 3000; n++) begin
      in_t x;
      x.rst_n = ($urandom_range(0, 63) != 0);
      x.valid = ($urandom_range(0, 7) != 0);
      x.rs    = AW'($urandom_range(0, 5));
      x.rt    = AW'($urandom_range(0, 5));
      x.urs   = 1'($urandom_range(0, 1));
      x.urt   = 1'($urandom_range(0, 1));
      x.rd    = AW'($urandom_range(0, 5));
      x.mr    = ($urandom_range(0, 2) == 0);
      x.rw    = x.mr | 1'($urandom_range(0, 1));
      x.flush = ($urandom_range(0, 7) == 0);
      run_cycle(x);
      check_model("rand");
    end

    // Saturation: a load that reads its own destination stalls every other cycle.
    run_cycle(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    ld = mk(1, 1, 2, 0, 1, 0, 2, 1, 1, 0);
    for (int n = 0; n < 2 * (CNT_MAX + 1) + 20; n++) begin
      run_cycle(ld);
      check_model("sat");
    end
    check("sat.all_ones", 32'(stall_cnt_o), 32'(CNT_MAX));

    // Reset asserted in a cycle where the load-use stall is pending.
    guard = 0;
    while (!model_stall(ld) && guard < 4) begin
      run_cycle(ld);
      guard++;
    end
    check("rst_stall.pending", 32'(model_stall(ld)), 32'(1));
    ld.rst_n = 1'b0;
    run_cycle(ld);
    check("rst_stall.stall_before", 32'(s_stall), 32'(1));
    check("rst_stall.cnt", 32'(s_cnt), 32'(0));
    check("rst_stall.fwd_a", 32'(s_fa), 32'(0));
    check("rst_stall.fwd_b", 32'(s_fb), 32'(0));
    ld.rst_n = 1'b1;
    run_cycle(ld);
    check("rst_stall.no_retain", 32'(s_stall), 32'(0));
    check("rst_stall.cnt_after", 32'(s_cnt), 32'(0));

    run_cycle(idle);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
